// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// requester identifiers and default widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int CONF_W_DEF = 8;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DMA_ACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Two-input round-robin picker: a lone eligible requester wins outright,
// a tie goes to whichever requester was not granted last.
import mem_arb_pkg::*;

module rr_select (
    input  logic i_elig_cpu,
    input  logic i_elig_dma,
    input  logic i_last_id,
    output logic o_grant_valid,
    output logic o_grant_id,
    output logic o_conflict
);

    always_comb begin
        o_grant_valid = i_elig_cpu | i_elig_dma;
        o_conflict    = i_elig_cpu & i_elig_dma;
        o_grant_id    = REQ_CPU;
        if (i_elig_cpu && i_elig_dma) begin
            o_grant_id = ~i_last_id;
        end else if (i_elig_dma) begin
            o_grant_id = REQ_DMA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port data memory between the CPU and the DMA/loader
// port; registered memory command, registered read return, conflict counter.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CONF_W = CONF_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    // Handshake: a requester raises req with we/addr/wdata and holds them
    // stable until it sees its one-cycle gnt; the command is on the memory
    // bus during that gnt cycle, and a read's data returns with rvalid in
    // the following cycle. A requester whose gnt is high is not eligible.
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_rvalid,
    input  logic              i_dma_req,
    input  logic              i_dma_we,
    input  logic [ADDR_W-1:0] i_dma_addr,
    input  logic [DATA_W-1:0] i_dma_wdata,
    output logic              o_dma_gnt,
    output logic [DATA_W-1:0] o_dma_rdata,
    output logic              o_dma_rvalid,
    output logic              o_mem_write,
    output logic              o_mem_load,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [CONF_W-1:0] o_conflicts,
    output logic [1:0]        o_dbg_state
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_last_id;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;
    logic              r_cpu_rvalid;
    logic              r_dma_rvalid;
    logic [CONF_W-1:0] r_conflicts;

    logic w_cpu_gnt;
    logic w_dma_gnt;
    logic w_cpu_elig;
    logic w_dma_elig;
    logic w_grant_valid;
    logic w_grant_id;
    logic w_conflict;
    logic w_busy;

    assign w_cpu_gnt  = (r_state == CPU_ACC);
    assign w_dma_gnt  = (r_state == DMA_ACC);
    assign w_busy     = w_cpu_gnt | w_dma_gnt;
    assign w_cpu_elig = i_cpu_req & ~w_cpu_gnt;
    assign w_dma_elig = i_dma_req & ~w_dma_gnt;

    rr_select u_rr_select (
        .i_elig_cpu    (w_cpu_elig),
        .i_elig_dma    (w_dma_elig),
        .i_last_id     (r_last_id),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id),
        .o_conflict    (w_conflict)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = IDLE;
        if (w_grant_valid) begin
            w_next_state = (w_grant_id == REQ_CPU) ? CPU_ACC : DMA_ACC;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_id    <= REQ_DMA;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_conflicts  <= '0;
        end else begin
            // Read data is captured at the end of the access cycle itself,
            // since the memory read is combinational on mem_addr.
            r_cpu_rvalid <= w_cpu_gnt & ~r_mem_we;
            r_dma_rvalid <= w_dma_gnt & ~r_mem_we;
            if (w_cpu_gnt && !r_mem_we) begin
                r_cpu_rdata <= i_mem_rdata;
            end
            if (w_dma_gnt && !r_mem_we) begin
                r_dma_rdata <= i_mem_rdata;
            end

            if (w_grant_valid) begin
                r_last_id <= w_grant_id;
                if (w_grant_id == REQ_CPU) begin
                    r_mem_we    <= i_cpu_we;
                    r_mem_addr  <= i_cpu_addr;
                    r_mem_wdata <= i_cpu_wdata;
                end else begin
                    r_mem_we    <= i_dma_we;
                    r_mem_addr  <= i_dma_addr;
                    r_mem_wdata <= i_dma_wdata;
                end
            end

            if (w_conflict && (r_conflicts != {CONF_W{1'b1}})) begin
                r_conflicts <= r_conflicts + {{(CONF_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_cpu_gnt    = w_cpu_gnt;
    assign o_dma_gnt    = w_dma_gnt;
    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_dma_rdata  = r_dma_rdata;
    assign o_cpu_rvalid = r_cpu_rvalid;
    assign o_dma_rvalid = r_dma_rvalid;
    assign o_mem_write  = w_busy & r_mem_we;
    assign o_mem_load   = w_busy & ~r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_conflicts  = r_conflicts;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for the steady-state
// behaviour plus hand-written sequences for saturation and reset corners.
module tb_mem_arbiter;

    logic       clk;
    logic       rst_n;
    logic       cpu_req, cpu_we, dma_req, dma_we;
    logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic       cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [7:0] cpu_rdata, dma_rdata;
    logic       mem_write, mem_load;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] conflicts;
    logic [1:0] dbg_state;

    logic       pre_we;
    logic [7:0] pre_addr, pre_data;
    logic [7:0] mem [256];

    int n_vec;
    int n_err;

    typedef struct {
        logic       c_req;
        logic       c_we;
        logic [7:0] c_addr;
        logic [7:0] c_wdata;
        logic       d_req;
        logic       d_we;
        logic [7:0] d_addr;
        logic [7:0] d_wdata;
        logic       e_cgnt;
        logic       e_dgnt;
        logic       e_wr;
        logic       e_ld;
        logic [7:0] e_addr;
        logic [7:0] e_wdata;
        logic       e_crv;
        logic [7:0] e_crd;
        logic       e_drv;
        logic [7:0] e_drd;
        logic [7:0] e_conf;
    } vec_t;

    vec_t vecs [22];

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .CONF_W(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_gnt    (cpu_gnt),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_rvalid (cpu_rvalid),
        .i_dma_req    (dma_req),
        .i_dma_we     (dma_we),
        .i_dma_addr   (dma_addr),
        .i_dma_wdata  (dma_wdata),
        .o_dma_gnt    (dma_gnt),
        .o_dma_rdata  (dma_rdata),
        .o_dma_rvalid (dma_rvalid),
        .o_mem_write  (mem_write),
        .o_mem_load   (mem_load),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_conflicts  (conflicts),
        .o_dbg_state  (dbg_state)
    );

    // clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c_req, input logic c_we, input logic [7:0] c_addr,
                         input logic [7:0] c_wdata, input logic d_req, input logic d_we,
                         input logic [7:0] d_addr, input logic [7:0] d_wdata);
        cpu_req   = c_req;
        cpu_we    = c_we;
        cpu_addr  = c_addr;
        cpu_wdata = c_wdata;
        dma_req   = d_req;
        dma_we    = d_we;
        dma_addr  = d_addr;
        dma_wdata = d_wdata;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_we   = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // one iteration that produces exactly one tie and returns to IDLE
    task automatic conflict_iter();
        drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
        step();
        if (cpu_gnt) cpu_req = 1'b0;
        else         dma_req = 1'b0;
        step();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b1;
        pre_we = 1'b0;
        pre_addr = 8'h00;
        pre_data = 8'h00;
        drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b1, 8'h06, 8'h11);

        //                c_req c_we  c_addr c_wd   d_req d_we  d_addr d_wd   cgnt  dgnt  wr    ld    addr   wdata  crv   crd    drv   drd    conf
        vecs[0]  = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 1'b1, 8'h2A, 1'b0, 8'h00, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h06, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 8'h06, 8'h11, 1'b0, 8'h2A, 1'b0, 8'h00, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h06, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h06, 8'h11, 1'b0, 8'h2A, 1'b0, 8'h00, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h07, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07, 8'h22, 1'b0, 8'h2A, 1'b0, 8'h00, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h07, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07, 8'h22, 1'b0, 8'h2A, 1'b0, 8'h00, 8'd0};
        vecs[6]  = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h2A, 1'b0, 8'h00, 8'd0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 1'b1, 8'h77, 1'b0, 8'h00, 8'd0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h77, 1'b1, 8'h3C, 8'd0};
        vecs[9]  = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 8'h77, 1'b0, 8'h3C, 8'd1};
        vecs[10] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b1, 8'h2A, 1'b0, 8'h3C, 8'd1};
        vecs[11] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 8'h2A, 1'b1, 8'h77, 8'd1};
        vecs[12] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b1, 8'h2A, 1'b0, 8'h77, 8'd1};
        vecs[13] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 8'h2A, 1'b1, 8'h77, 8'd1};
        vecs[14] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b1, 8'h2A, 1'b0, 8'h77, 8'd1};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h2A, 1'b1, 8'h77, 8'd1};
        vecs[16] = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 8'h00, 1'b0, 8'h2A, 1'b0, 8'h77, 8'd1};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 8'h3C, 1'b0, 8'h77, 8'd1};
        vecs[18] = '{1'b1, 1'b1, 8'h30, 8'h5A, 1'b1, 1'b1, 8'h31, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'h31, 8'hA5, 1'b0, 8'h3C, 1'b0, 8'h77, 8'd2};
        vecs[19] = '{1'b1, 1'b1, 8'h30, 8'h5A, 1'b1, 1'b1, 8'h31, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 8'h5A, 1'b0, 8'h3C, 1'b0, 8'h77, 8'd2};
        vecs[20] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h30, 8'h5A, 1'b0, 8'h3C, 1'b0, 8'h77, 8'd2};
        vecs[21] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h30, 8'h5A, 1'b0, 8'h3C, 1'b0, 8'h77, 8'd2};

        // reset with both requests high, memory preloaded meanwhile
        #1 rst_n = 1'b0;
        preload(8'h05, 8'h2A);
        preload(8'h10, 8'h77);
        preload(8'h20, 8'h3C);
        preload(8'h08, 8'hC3);
        check("rst cpu_gnt",    cpu_gnt,    1'b0);
        check("rst dma_gnt",    dma_gnt,    1'b0);
        check("rst mem_write",  mem_write,  1'b0);
        check("rst mem_load",   mem_load,   1'b0);
        check("rst mem_addr",   mem_addr,   8'h00);
        check("rst mem_wdata",  mem_wdata,  8'h00);
        check("rst cpu_rvalid", cpu_rvalid, 1'b0);
        check("rst dma_rvalid", dma_rvalid, 1'b0);
        check("rst cpu_rdata",  cpu_rdata,  8'h00);
        check("rst dma_rdata",  dma_rdata,  8'h00);
        check("rst conflicts",  conflicts,  8'd0);
        check("rst state",      dbg_state,  2'd0);

        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b1;

        // table: isolated read, DMA write spacing, overlap, round robin
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wdata,
                  vecs[i].d_req, vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wdata);
            step();
            check($sformatf("v%0d cpu_gnt", i),    cpu_gnt,    vecs[i].e_cgnt);
            check($sformatf("v%0d dma_gnt", i),    dma_gnt,    vecs[i].e_dgnt);
            check($sformatf("v%0d mem_write", i),  mem_write,  vecs[i].e_wr);
            check($sformatf("v%0d mem_load", i),   mem_load,   vecs[i].e_ld);
            check($sformatf("v%0d mem_addr", i),   mem_addr,   vecs[i].e_addr);
            check($sformatf("v%0d mem_wdata", i),  mem_wdata,  vecs[i].e_wdata);
            check($sformatf("v%0d cpu_rvalid", i), cpu_rvalid, vecs[i].e_crv);
            check($sformatf("v%0d cpu_rdata", i),  cpu_rdata,  vecs[i].e_crd);
            check($sformatf("v%0d dma_rvalid", i), dma_rvalid, vecs[i].e_drv);
            check($sformatf("v%0d dma_rdata", i),  dma_rdata,  vecs[i].e_drd);
            check($sformatf("v%0d conflicts", i),  conflicts,  vecs[i].e_conf);
        end
        check("mem[06]", mem[8'h06], 8'h11);
        check("mem[07]", mem[8'h07], 8'h22);
        check("mem[30]", mem[8'h30], 8'h5A);
        check("mem[31]", mem[8'h31], 8'hA5);

        // conflict counter: 2 so far, then count up to saturation
        for (int k = 0; k < 10; k++) conflict_iter();
        check("conf after 10 ties", conflicts, 8'd12);
        for (int k = 0; k < 290; k++) conflict_iter();
        check("conf saturated", conflicts, 8'd255);
        conflict_iter();
        check("conf stays saturated", conflicts, 8'd255);

        // reset in the middle of a CPU write access
        drive(1'b1, 1'b1, 8'h08, 8'h99, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        check("pre-rst cpu_gnt", cpu_gnt, 1'b1);
        check("pre-rst mem_write", mem_write, 1'b1);
        #2;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("async rst mem_write", mem_write, 1'b0);
        check("async rst cpu_gnt", cpu_gnt, 1'b0);
        check("async rst mem_addr", mem_addr, 8'h00);
        check("async rst conflicts", conflicts, 8'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("post-rst%0d cpu_gnt", k), cpu_gnt, 1'b0);
            check($sformatf("post-rst%0d cpu_rvalid", k), cpu_rvalid, 1'b0);
        end
        check("mem[08] untouched", mem[8'h08], 8'hC3);

        // pointer is back at DMA: CPU wins the first tie, DMA follows
        drive(1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
        step();
        check("tie1 cpu_gnt", cpu_gnt, 1'b1);
        check("tie1 dma_gnt", dma_gnt, 1'b0);
        check("tie1 conflicts", conflicts, 8'd1);
        cpu_req = 1'b0;
        step();
        check("tie2 dma_gnt", dma_gnt, 1'b1);
        check("tie2 cpu_rdata", cpu_rdata, 8'h2A);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        check("tie3 dma_rdata", dma_rdata, 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
